// File: rtl/awb_gain_calc.sv
// Gray-world auto-white-balance gain estimator: per-frame channel sums feed a
// bit-serial restoring divider that produces Q3.10 gains for R and B (G fixed at 1.0).
module awb_gain_calc #(
    parameter int PIXEL_WIDTH        = 8,
    parameter int COE_WIDTH          = 16,
    parameter int COE_FRACTION_WIDTH = 10,
    parameter int COE_COUNT          = 3,
    parameter int SUM_WIDTH          = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PIXEL_WIDTH*3-1:0]          di_i,
    input  logic                              de_i,
    input  logic                              hs_i,
    input  logic                              vs_i,
    input  logic                              en_i,
    output logic [COE_WIDTH*COE_COUNT-1:0]    coe_o,
    output logic                              coe_vld_o,
    output logic                              busy_o
);

    localparam int N     = SUM_WIDTH + COE_FRACTION_WIDTH;
    localparam int CNT_W = $clog2(N);
    localparam logic [COE_WIDTH-1:0] UNITY    = COE_WIDTH'(1 << COE_FRACTION_WIDTH);
    localparam logic [COE_WIDTH-1:0] GAIN_MAX = COE_WIDTH'((1 << (COE_FRACTION_WIDTH + 3)) - 1);
    localparam logic [N-1:0]         QUOT_MAX = N'((1 << (COE_FRACTION_WIDTH + 3)) - 1);

    typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, UPDATE} state_t;

    state_t                          state_q, state_d;
    logic                            vs_q, vs_d;
    logic                            first_frame_q, first_frame_d;
    logic [SUM_WIDTH-1:0]            sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
    logic [SUM_WIDTH-1:0]            snap_r_q, snap_r_d, snap_g_q, snap_g_d, snap_b_q, snap_b_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [N-1:0]                    num_q, num_d;
    logic [SUM_WIDTH-1:0]            rem_q, rem_d;
    logic [N-1:0]                    quot_q, quot_d;
    logic [COE_WIDTH-1:0]            coe_r_res_q, coe_r_res_d;
    logic [COE_WIDTH*COE_COUNT-1:0]  coe_q, coe_d;
    logic                            coe_vld_q, coe_vld_d;

    logic                            vs_rise;
    logic                            take;
    logic [SUM_WIDTH-1:0]            base_r, base_g, base_b;
    logic [SUM_WIDTH-1:0]            divisor;
    logic [SUM_WIDTH:0]              rem_shift;
    logic                            rem_ge;
    logic [SUM_WIDTH-1:0]            rem_next;
    logic [N-1:0]                    quot_next;
    logic [N-1:0]                    num_init;
    logic                            unused_hs;

    assign unused_hs = hs_i;

    function automatic logic [SUM_WIDTH-1:0] sat_acc(input logic [SUM_WIDTH-1:0] sum,
                                                     input logic [PIXEL_WIDTH-1:0] pix);
        logic [SUM_WIDTH:0] s;
        s = {1'b0, sum} + (SUM_WIDTH + 1)'(pix);
        sat_acc = s[SUM_WIDTH] ? '1 : s[SUM_WIDTH-1:0];
    endfunction

    // A zero divisor would yield an all-ones quotient; unity gain is the safe answer there.
    function automatic logic [COE_WIDTH-1:0] sat_gain(input logic [N-1:0] quot,
                                                      input logic [SUM_WIDTH-1:0] div);
        if (div == '0)
            sat_gain = UNITY;
        else if (quot > QUOT_MAX)
            sat_gain = GAIN_MAX;
        else
            sat_gain = quot[COE_WIDTH-1:0];
    endfunction

    assign vs_rise  = vs_i & ~vs_q;
    assign take     = vs_rise && (state_q == IDLE) && en_i && !first_frame_q;
    assign base_r   = vs_rise ? '0 : sum_r_q;
    assign base_g   = vs_rise ? '0 : sum_g_q;
    assign base_b   = vs_rise ? '0 : sum_b_q;
    assign divisor  = (state_q == DIV_B) ? snap_b_q : snap_r_q;
    assign rem_shift = {rem_q, num_q[N-1]};
    assign rem_ge    = rem_shift >= {1'b0, divisor};
    assign rem_next  = rem_ge ? SUM_WIDTH'(rem_shift - {1'b0, divisor}) : rem_shift[SUM_WIDTH-1:0];
    assign quot_next = {quot_q[N-2:0], rem_ge};
    assign num_init  = {snap_g_q, {COE_FRACTION_WIDTH{1'b0}}};

    always_comb begin
        state_d       = state_q;
        vs_d          = vs_i;
        first_frame_d = vs_rise ? 1'b0 : first_frame_q;
        sum_r_d       = de_i ? sat_acc(base_r, di_i[0 +: PIXEL_WIDTH]) : base_r;
        sum_g_d       = de_i ? sat_acc(base_g, di_i[PIXEL_WIDTH +: PIXEL_WIDTH]) : base_g;
        sum_b_d       = de_i ? sat_acc(base_b, di_i[2*PIXEL_WIDTH +: PIXEL_WIDTH]) : base_b;
        snap_r_d      = snap_r_q;
        snap_g_d      = snap_g_q;
        snap_b_d      = snap_b_q;
        cnt_d         = cnt_q;
        num_d         = num_q;
        rem_d         = rem_q;
        quot_d        = quot_q;
        coe_r_res_d   = coe_r_res_q;
        coe_d         = coe_q;
        coe_vld_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (take) begin
                    snap_r_d = sum_r_q;
                    snap_g_d = sum_g_q;
                    snap_b_d = sum_b_q;
                    num_d    = {sum_g_q, {COE_FRACTION_WIDTH{1'b0}}};
                    rem_d    = '0;
                    quot_d   = '0;
                    cnt_d    = '0;
                    state_d  = DIV_R;
                end
            end
            DIV_R, DIV_B: begin
                num_d  = num_q << 1;
                rem_d  = rem_next;
                quot_d = quot_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d = '0;
                    if (state_q == DIV_R) begin
                        coe_r_res_d = sat_gain(quot_next, snap_r_q);
                        num_d       = num_init;
                        rem_d       = '0;
                        quot_d      = '0;
                        state_d     = DIV_B;
                    end else begin
                        state_d = UPDATE;
                    end
                end
            end
            UPDATE: begin
                coe_d     = {sat_gain(quot_q, snap_b_q), UNITY, coe_r_res_q};
                coe_vld_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            vs_q          <= 1'b0;
            first_frame_q <= 1'b1;
            sum_r_q       <= '0;
            sum_g_q       <= '0;
            sum_b_q       <= '0;
            snap_r_q      <= '0;
            snap_g_q      <= '0;
            snap_b_q      <= '0;
            cnt_q         <= '0;
            num_q         <= '0;
            rem_q         <= '0;
            quot_q        <= '0;
            coe_r_res_q   <= UNITY;
            coe_q         <= {COE_COUNT{UNITY}};
            coe_vld_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_q          <= vs_d;
            first_frame_q <= first_frame_d;
            sum_r_q       <= sum_r_d;
            sum_g_q       <= sum_g_d;
            sum_b_q       <= sum_b_d;
            snap_r_q      <= snap_r_d;
            snap_g_q      <= snap_g_d;
            snap_b_q      <= snap_b_d;
            cnt_q         <= cnt_d;
            num_q         <= num_d;
            rem_q         <= rem_d;
            quot_q        <= quot_d;
            coe_r_res_q   <= coe_r_res_d;
            coe_q         <= coe_d;
            coe_vld_q     <= coe_vld_d;
        end
    end

    assign coe_o     = coe_q;
    assign coe_vld_o = coe_vld_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_awb_gain_calc.sv
// Directed and randomized frames for awb_gain_calc, checked against a gray-world
// reference computed from frame sums with plain integer arithmetic.
module tb_awb_gain_calc;

    localparam int SW = 32;
    localparam int FW = 10;
    localparam int N  = SW + FW;
    localparam logic [47:0] UNITY3 = {16'h0400, 16'h0400, 16'h0400};

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] di_i;
    logic        de_i, hs_i, vs_i, en_i;
    logic [47:0] coe_o;
    logic        coe_vld_o, busy_o;

    int checks = 0;
    int errors = 0;

    longint      acc_r, acc_g, acc_b;
    bit          first_m;
    logic [47:0] exp_coe;

    awb_gain_calc dut (
        .clk       (clk),
        .rst       (rst),
        .di_i      (di_i),
        .de_i      (de_i),
        .hs_i      (hs_i),
        .vs_i      (vs_i),
        .en_i      (en_i),
        .coe_o     (coe_o),
        .coe_vld_o (coe_vld_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] gain(input longint num, input longint den);
        longint q;
        if (den == 0) return 16'h0400;
        q = (num * 1024) / den;
        if (q > 8191) return 16'h1FFF;
        return q[15:0];
    endfunction

    function automatic longint sat32(input longint v);
        return (v > 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : v;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        acc_r   = 0;
        acc_g   = 0;
        acc_b   = 0;
        first_m = 1'b1;
        exp_coe = UNITY3;
    endtask

    task automatic apply_reset();
        rst  = 1'b0;
        de_i = 1'b0;
        vs_i = 1'b0;
        hs_i = 1'b0;
        en_i = 1'b1;
        di_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(negedge clk);
        de_i  = 1'b1;
        vs_i  = 1'b0;
        di_i  = {b, g, r};
        acc_r = sat32(acc_r + r);
        acc_g = sat32(acc_g + g);
        acc_b = sat32(acc_b + b);
    endtask

    task automatic send_frame(input int n, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b);
        for (int i = 0; i < n; i++) send_pixel(r, g, b);
    endtask

    // Raises vsync once, watches a fixed window covering a full division, then checks the result.
    task automatic end_frame(input int drop_en_cycle);
        logic [47:0] exp_new;
        bit          take;
        int          vld_count;
        int          first_vld;
        take    = en_i && !first_m;
        exp_new = {gain(acc_g, acc_b), 16'h0400, gain(acc_g, acc_r)};
        acc_r   = 0;
        acc_g   = 0;
        acc_b   = 0;
        first_m = 1'b0;
        @(negedge clk);
        de_i = 1'b0;
        vs_i = 1'b1;
        vld_count = 0;
        first_vld = -1;
        for (int c = 1; c <= 2 * N + 20; c++) begin
            @(negedge clk);
            vs_i = 1'b0;
            if (c == drop_en_cycle) en_i = 1'b0;
            if (coe_vld_o) begin
                vld_count++;
                if (first_vld < 0) first_vld = c - 1;
            end
            if (c == 3) check_output("busy_mid", busy_o, take ? 1 : 0);
        end
        check_output("vld_count", vld_count, take ? 1 : 0);
        if (take) begin
            check_output("latency", first_vld, 2 * N + 1);
            exp_coe = exp_new;
        end
        check_output("coe", coe_o, exp_coe);
        check_output("busy_end", busy_o, 0);
    endtask

    initial begin
        logic [47:0] exp_new;
        int          vld_count;
        int          first_vld;
        int          n;
        logic [7:0]  r, g, b;
        bit          zero_r;

        rst = 1'b0;
        apply_reset();
        check_output("rst_coe", coe_o, UNITY3);
        check_output("rst_vld", coe_vld_o, 0);
        check_output("rst_busy", busy_o, 0);

        $display("[TB] dummy first frame then basic gains");
        send_frame(2, 8'd10, 8'd20, 8'd30);
        end_frame(0);
        send_frame(4, 8'd64, 8'd128, 8'd32);
        end_frame(0);
        check_output("basic_exact", coe_o, 48'h1000_0400_0800);

        $display("[TB] saturation and zero divisor");
        send_frame(3, 8'd8, 8'd255, 8'd255);
        end_frame(0);
        check_output("sat_exact", coe_o, 48'h0400_0400_1FFF);
        send_frame(5, 8'd0, 8'd100, 8'd50);
        end_frame(0);
        check_output("zero_r_exact", coe_o, 48'h0800_0400_0400);

        $display("[TB] enable low at frame end, enable dropped mid-division");
        en_i = 1'b0;
        send_frame(3, 8'd40, 8'd80, 8'd20);
        end_frame(0);
        en_i = 1'b1;
        send_frame(3, 8'd40, 8'd80, 8'd20);
        end_frame(30);
        check_output("en_drop_exact", coe_o, 48'h1000_0400_0800);
        en_i = 1'b1;

        $display("[TB] second vsync while busy");
        send_frame(3, 8'd100, 8'd50, 8'd200);
        exp_new = {gain(acc_g, acc_b), 16'h0400, gain(acc_g, acc_r)};
        acc_r = 0;
        acc_g = 0;
        acc_b = 0;
        @(negedge clk);
        de_i = 1'b0;
        vs_i = 1'b1;
        vld_count = 0;
        first_vld = -1;
        for (int c = 1; c <= 2 * N + 20; c++) begin
            @(negedge clk);
            vs_i = (c == 20);
            de_i = (c >= 5 && c < 15);
            di_i = {8'd1, 8'd250, 8'd3};
            if (coe_vld_o) begin
                vld_count++;
                if (first_vld < 0) first_vld = c - 1;
            end
        end
        exp_coe = exp_new;
        check_output("busy_vs_vld_count", vld_count, 1);
        check_output("busy_vs_latency", first_vld, 2 * N + 1);
        check_output("busy_vs_coe", coe_o, 48'h0100_0400_0200);

        $display("[TB] reset during second division");
        send_frame(2, 8'd50, 8'd60, 8'd70);
        @(negedge clk);
        de_i = 1'b0;
        vs_i = 1'b1;
        repeat (60) begin
            @(negedge clk);
            vs_i = 1'b0;
        end
        check_output("pre_rst_busy", busy_o, 1);
        rst = 1'b0;
        #1;
        check_output("mid_rst_coe", coe_o, UNITY3);
        check_output("mid_rst_busy", busy_o, 0);
        check_output("mid_rst_vld", coe_vld_o, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        send_frame(2, 8'd5, 8'd5, 8'd5);
        end_frame(0);
        send_frame(4, 8'd30, 8'd90, 8'd45);
        end_frame(0);
        check_output("post_rst_exact", coe_o, 48'h0800_0400_0C00);

        $display("[TB] randomized frames");
        for (int f = 0; f < 8; f++) begin
            n      = $urandom_range(1, 12);
            zero_r = ($urandom_range(0, 4) == 0);
            en_i   = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < n; i++) begin
                r = zero_r ? 8'd0 : 8'($urandom_range(0, 255));
                g = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(1, 255));
                send_pixel(r, g, b);
            end
            end_frame(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
